// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared widths, FSM encoding and refill-counter sizing for the PC redirect controller
package pc_ctrl_pkg;
    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        REDIRECT = 2'b01,
        REFILL   = 2'b10
    } state_t;

    // Down-counter width for the refill window; at least one bit even when the window is empty
    function automatic int refill_cnt_w(input int n);
        return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/pc_redirect_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at its maximum value instead of wrapping
//   i_Clk, i_Rst : clock, async active-high reset
//   i_Inc        : add one this cycle
//   count        : current value, saturates at 2^CNT_W-1
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge i_Clk or posedge i_Rst)
        if (i_Rst)
            count <= '0;
        else if (i_Inc && count != '1)
            count <= count + CNT_W'(1);
endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: misprediction recovery - squash, held redirect to Fetch, refill window, BTB update
//   i_Clk, i_Rst                  : clock, async active-high reset
//   i_EX_Valid, i_BranchInstr,
//   i_JumpInstr, i_PPC_Eq         : EX-stage control-flow evaluation
//   i_PC_VIC, i_EX_PC             : corrected next PC, PC of the EX instruction
//   i_Fetch_Ready                 : Fetch takes the redirect this cycle
//   o_Redirect_Valid/PC           : held redirect request to Fetch
//   o_Flush_IFID, o_Flush_IDEX    : squash wrong-path pipeline registers
//   o_BTB_Upd_En/PC/Tgt           : one-cycle BTB write
//   o_Mispred_Cnt                 : saturating mispredict count
module pc_redirect_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int WIDTH      = pc_ctrl_pkg::DEF_WIDTH,
    parameter int REFILL_CYC = 2,
    parameter int CNT_W      = 16
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_EX_Valid,
    input  logic             i_BranchInstr,
    input  logic             i_JumpInstr,
    input  logic             i_PPC_Eq,
    input  logic [WIDTH-1:0] i_PC_VIC,
    input  logic [WIDTH-1:0] i_EX_PC,
    input  logic             i_Fetch_Ready,
    output logic             o_Redirect_Valid,
    output logic [WIDTH-1:0] o_Redirect_PC,
    output logic             o_Flush_IFID,
    output logic             o_Flush_IDEX,
    output logic             o_BTB_Upd_En,
    output logic [WIDTH-1:0] o_BTB_Upd_PC,
    output logic [WIDTH-1:0] o_BTB_Upd_Tgt,
    output logic [CNT_W-1:0] o_Mispred_Cnt
);
    localparam int RW = refill_cnt_w(REFILL_CYC);
    localparam logic [RW-1:0] REFILL_LOAD = RW'((REFILL_CYC == 0) ? 0 : REFILL_CYC - 1);

    state_t          state, nxt;
    logic [RW-1:0]   refill_cnt;
    logic [WIDTH-1:0] redirect_pc;
    logic            mp, accept, xfer;

    // Mispredicts only count when the pipeline is not already recovering
    assign mp     = i_EX_Valid & (i_BranchInstr | i_JumpInstr) & ~i_PPC_Eq;
    assign accept = (state == IDLE) & mp;
    assign xfer   = (state == REDIRECT) & i_Fetch_Ready;

    always_comb begin
        nxt = state == IDLE     ? (accept ? REDIRECT : IDLE) :
              state == REDIRECT ? (i_Fetch_Ready ? ((REFILL_CYC == 0) ? IDLE : REFILL) : REDIRECT) :
              (state == REFILL && refill_cnt != '0) ? REFILL : IDLE;
    end

    always_ff @(posedge i_Clk or posedge i_Rst)
        if (i_Rst) begin
            state         <= IDLE;
            refill_cnt    <= '0;
            redirect_pc   <= '0;
            o_BTB_Upd_En  <= 1'b0;
            o_BTB_Upd_PC  <= '0;
            o_BTB_Upd_Tgt <= '0;
        end else begin
            state        <= nxt;
            o_BTB_Upd_En <= accept;
            if (accept) begin
                redirect_pc   <= i_PC_VIC;
                o_BTB_Upd_PC  <= i_EX_PC;
                o_BTB_Upd_Tgt <= i_PC_VIC;
            end
            if (xfer)
                refill_cnt <= REFILL_LOAD;
            else if (state == REFILL && refill_cnt != '0)
                refill_cnt <= refill_cnt - RW'(1);
        end

    assign o_Redirect_Valid = (state == REDIRECT);
    assign o_Redirect_PC    = redirect_pc;
    assign o_Flush_IFID     = accept | (state == REDIRECT);
    assign o_Flush_IDEX     = accept | (state == REDIRECT);

    sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .i_Inc (accept),
        .count (o_Mispred_Cnt)
    );
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed checks of redirect sequencing, backpressure, ignore windows and counter saturation
module tb_pc_redirect_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid, br, jmp, ppc_eq, fetch_ready;
    logic [31:0] pc_vic, ex_pc;
    int          checks = 0;
    int          errors = 0;

    logic        a_rv, a_fi, a_fe, a_be;
    logic [31:0] a_rpc, a_bpc, a_btgt;
    logic [15:0] a_cnt;
    logic        b_rv, b_fi, b_fe, b_be;
    logic [31:0] b_rpc, b_bpc, b_btgt;
    logic [1:0]  b_cnt;

    always #5 clk = ~clk;

    pc_redirect_ctrl #(.WIDTH(32), .REFILL_CYC(2), .CNT_W(16)) dut_a (
        .i_Clk(clk), .i_Rst(rst), .i_EX_Valid(ex_valid), .i_BranchInstr(br), .i_JumpInstr(jmp),
        .i_PPC_Eq(ppc_eq), .i_PC_VIC(pc_vic), .i_EX_PC(ex_pc), .i_Fetch_Ready(fetch_ready),
        .o_Redirect_Valid(a_rv), .o_Redirect_PC(a_rpc), .o_Flush_IFID(a_fi), .o_Flush_IDEX(a_fe),
        .o_BTB_Upd_En(a_be), .o_BTB_Upd_PC(a_bpc), .o_BTB_Upd_Tgt(a_btgt), .o_Mispred_Cnt(a_cnt)
    );

    pc_redirect_ctrl #(.WIDTH(32), .REFILL_CYC(0), .CNT_W(2)) dut_b (
        .i_Clk(clk), .i_Rst(rst), .i_EX_Valid(ex_valid), .i_BranchInstr(br), .i_JumpInstr(jmp),
        .i_PPC_Eq(ppc_eq), .i_PC_VIC(pc_vic), .i_EX_PC(ex_pc), .i_Fetch_Ready(fetch_ready),
        .o_Redirect_Valid(b_rv), .o_Redirect_PC(b_rpc), .o_Flush_IFID(b_fi), .o_Flush_IDEX(b_fe),
        .o_BTB_Upd_En(b_be), .o_BTB_Upd_PC(b_bpc), .o_BTB_Upd_Tgt(b_btgt), .o_Mispred_Cnt(b_cnt)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ex_valid = 0; br = 0; jmp = 0; ppc_eq = 0; fetch_ready = 0; pc_vic = 0; ex_pc = 0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
        step();
    endtask

    task automatic drive_mp(input logic [31:0] epc, input logic [31:0] vic);
        ex_valid = 1; br = 1; jmp = 0; ppc_eq = 0; ex_pc = epc; pc_vic = vic;
    endtask

    task automatic test_reset;
        do_reset();
        drive_mp(32'h100, 32'h200);
        step();
        ex_valid = 0;
        #1;
        checks++; if (a_rv !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %0h exp 1", a_rv); end
        #2 rst = 1;
        #1;
        checks++; if (a_rv !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0h exp 0", a_rv); end
        checks++; if ({a_fi, a_fe, a_be} !== 3'b000) begin errors++; $display("FAIL rst_flush_btb: got %b exp 000", {a_fi, a_fe, a_be}); end
        checks++; if (a_rpc !== 32'h0 || a_bpc !== 32'h0 || a_btgt !== 32'h0) begin errors++; $display("FAIL rst_pcs: got %h %h %h exp 0 0 0", a_rpc, a_bpc, a_btgt); end
        checks++; if (a_cnt !== 16'h0) begin errors++; $display("FAIL rst_cnt: got %0d exp 0", a_cnt); end
        step();
        rst = 0;
        step();
        checks++; if (a_rv !== 1'b0 || a_be !== 1'b0) begin errors++; $display("FAIL rst_after: got rv=%0h be=%0h exp 0 0", a_rv, a_be); end
    endtask

    task automatic test_branch_mispredict;
        do_reset();
        drive_mp(32'h100, 32'h200);
        fetch_ready = 1;
        #1;
        checks++; if (a_fi !== 1'b1 || a_fe !== 1'b1) begin errors++; $display("FAIL t2_flush_T: got %b%b exp 11", a_fi, a_fe); end
        checks++; if (a_rv !== 1'b0) begin errors++; $display("FAIL t2_valid_T: got %0h exp 0", a_rv); end
        step();
        ex_valid = 0;
        #1;
        checks++; if (a_rv !== 1'b1 || a_rpc !== 32'h200) begin errors++; $display("FAIL t2_redirect: got %0h %h exp 1 200", a_rv, a_rpc); end
        checks++; if (a_be !== 1'b1 || a_bpc !== 32'h100 || a_btgt !== 32'h200) begin errors++; $display("FAIL t2_btb: got %0h %h %h exp 1 100 200", a_be, a_bpc, a_btgt); end
        checks++; if (a_cnt !== 16'd1) begin errors++; $display("FAIL t2_cnt: got %0d exp 1", a_cnt); end
        checks++; if (a_fi !== 1'b1 || a_fe !== 1'b1) begin errors++; $display("FAIL t2_flush_T1: got %b%b exp 11", a_fi, a_fe); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if ({a_rv, a_fi, a_fe, a_be} !== 4'b0000) begin errors++; $display("FAIL t2_refill%0d: got %b exp 0000", i, {a_rv, a_fi, a_fe, a_be}); end
        end
        step();
        drive_mp(32'h104, 32'h300);
        #1;
        checks++; if (a_fi !== 1'b1) begin errors++; $display("FAIL t2_idle_T4: got %0h exp 1", a_fi); end
        idle_inputs();
    endtask

    task automatic test_backpressure;
        do_reset();
        drive_mp(32'h100, 32'h200);
        step();
        ex_valid = 0;
        pc_vic = 32'h300;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) fetch_ready = 1;
            #1;
            checks++; if (a_rv !== 1'b1 || a_rpc !== 32'h200) begin errors++; $display("FAIL t3_hold%0d: got %0h %h exp 1 200", i, a_rv, a_rpc); end
            checks++; if (a_be !== (i == 0)) begin errors++; $display("FAIL t3_pulse%0d: got %0h exp %0d", i, a_be, i == 0); end
            step();
        end
        checks++; if (a_rv !== 1'b0 || a_btgt !== 32'h200) begin errors++; $display("FAIL t3_after: got %0h %h exp 0 200", a_rv, a_btgt); end
        checks++; if (a_cnt !== 16'd1) begin errors++; $display("FAIL t3_cnt: got %0d exp 1", a_cnt); end
        idle_inputs();
    endtask

    task automatic test_correct_prediction;
        logic [3:0] vec [4];
        vec[0] = 4'b1101;
        vec[1] = 4'b1011;
        vec[2] = 4'b1000;
        vec[3] = 4'b0100;
        do_reset();
        fetch_ready = 1;
        for (int i = 0; i < 4; i++) begin
            {ex_valid, br, jmp, ppc_eq} = vec[i];
            #1;
            checks++; if (a_fi !== 1'b0 || a_fe !== 1'b0) begin errors++; $display("FAIL t4_flush%0d: got %b%b exp 00", i, a_fi, a_fe); end
            step();
            checks++; if (a_rv !== 1'b0 || a_be !== 1'b0 || a_cnt !== 16'd0) begin errors++; $display("FAIL t4_quiet%0d: got %0h %0h %0d exp 0 0 0", i, a_rv, a_be, a_cnt); end
        end
        idle_inputs();
    endtask

    task automatic test_ignore_while_busy;
        do_reset();
        drive_mp(32'h100, 32'h200);
        step();
        pc_vic = 32'h400;
        #1;
        checks++; if (a_cnt !== 16'd1 || a_be !== 1'b1) begin errors++; $display("FAIL t5_first: got %0d %0h exp 1 1", a_cnt, a_be); end
        step();
        checks++; if (a_be !== 1'b0 || a_cnt !== 16'd1 || a_rpc !== 32'h200) begin errors++; $display("FAIL t5_redirect: got %0h %0d %h exp 0 1 200", a_be, a_cnt, a_rpc); end
        fetch_ready = 1;
        step();
        for (int i = 0; i < 2; i++) begin
            checks++; if (a_fi !== 1'b0 || a_rv !== 1'b0 || a_be !== 1'b0 || a_cnt !== 16'd1) begin errors++; $display("FAIL t5_refill%0d: got fi=%0h rv=%0h be=%0h cnt=%0d exp 0 0 0 1", i, a_fi, a_rv, a_be, a_cnt); end
            step();
        end
        checks++; if (a_fi !== 1'b1) begin errors++; $display("FAIL t5_reaccept: got %0h exp 1", a_fi); end
        idle_inputs();
        do_reset();
        drive_mp(32'h500, 32'h600);
        jmp = 1;
        fetch_ready = 1;
        step();
        #1;
        checks++; if (b_rv !== 1'b1 || b_cnt !== 2'd1) begin errors++; $display("FAIL t5_r0_redirect: got %0h %0d exp 1 1", b_rv, b_cnt); end
        pc_vic = 32'h700;
        step();
        checks++; if (b_fi !== 1'b1 || b_rv !== 1'b0) begin errors++; $display("FAIL t5_r0_accept: got fi=%0h rv=%0h exp 1 0", b_fi, b_rv); end
        step();
        checks++; if (b_rv !== 1'b1 || b_be !== 1'b1 || b_rpc !== 32'h700 || b_cnt !== 2'd2) begin errors++; $display("FAIL t5_r0_second: got %0h %0h %h %0d exp 1 1 700 2", b_rv, b_be, b_rpc, b_cnt); end
        idle_inputs();
    endtask

    task automatic test_saturation;
        do_reset();
        fetch_ready = 1;
        for (int k = 1; k <= 5; k++) begin
            drive_mp(32'h10 * k, 32'h20 * k);
            step();
            ex_valid = 0;
            #1;
            checks++; if (b_cnt !== ((k < 3) ? k : 3)) begin errors++; $display("FAIL t6_cnt%0d: got %0d exp %0d", k, b_cnt, (k < 3) ? k : 3); end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_branch_mispredict();
        test_backpressure();
        test_correct_prediction();
        test_ignore_while_busy();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
